// File: rtl/kfps2kb_receive_data.sv
// ---------------------------------------------------------------------------
// kfps2kb_receive_data
//
// Receives device-to-host frames from a PS/2 keyboard. Each frame has
// 11 bits: a start bit (0), 8 data bits sent LSB first, an odd parity bit,
// and a stop bit (1). Bits are sampled on each falling edge of device_clock.
// Good bytes are placed in a one-deep output register with a valid/ack
// handshake. Parity, framing, timeout and overrun conditions are each
// reported as a one-cycle pulse.
//
// Ports
//   clock             : system clock; all logic runs on its rising edge
//   reset_n           : asynchronous reset, active low
//   peripheral_clock  : slow timebase; its ticks drive the inactivity timeout
//   device_clock      : PS/2 clock line (asynchronous)
//   device_data       : PS/2 data line (asynchronous)
//   sending_data_flag : the host transmitter owns the bus; receive is held off
//   data_ack          : the consumer takes received_data
//   received_data     : last good byte
//   data_valid        : received_data has not been read yet
//   parity_error      : one-cycle pulse; a frame had even parity
//   framing_error     : one-cycle pulse; a frame had a stop bit of 0
//   timeout_error     : one-cycle pulse; a partial frame was dropped
//   overrun           : one-cycle pulse; an unread byte was overwritten
// ---------------------------------------------------------------------------
module kfps2kb_receive_data #(
  parameter logic [15:0] device_in_timeout = 16'd2000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       peripheral_clock,
  input  logic       device_clock,
  input  logic       device_data,
  input  logic       sending_data_flag,
  input  logic       data_ack,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       timeout_error,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state, state_next;
  logic [2:0]  bit_count, bit_count_next;
  logic [7:0]  shift, shift_next;
  logic        parity_bit, parity_bit_next;
  logic [15:0] tmo_count, tmo_count_next;

  // Result of the frame just closed by the stop-bit edge. It is applied to
  // the outputs one cycle later.
  logic        pend_good, pend_good_next;
  logic        pend_parity, pend_parity_next;
  logic        pend_framing, pend_framing_next;
  logic [7:0]  pend_data, pend_data_next;

  logic        tmo_hit;

  logic dclk_meta, dclk_sync, dclk_prev;
  logic ddat_meta, ddat_sync;
  logic pclk_meta, pclk_sync, pclk_prev;
  logic fe;
  logic pclk_rise;

  // Two-flop synchronizers for the asynchronous inputs, plus one extra
  // history flop on each clock so its edges can be detected. Reset loads 1
  // (bus idle high), so releasing reset never creates a false edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dclk_meta <= 1'b1;
      dclk_sync <= 1'b1;
      dclk_prev <= 1'b1;
      ddat_meta <= 1'b1;
      ddat_sync <= 1'b1;
      pclk_meta <= 1'b1;
      pclk_sync <= 1'b1;
      pclk_prev <= 1'b1;
    end else begin
      dclk_meta <= device_clock;
      dclk_sync <= dclk_meta;
      dclk_prev <= dclk_sync;
      ddat_meta <= device_data;
      ddat_sync <= ddat_meta;
      pclk_meta <= peripheral_clock;
      pclk_sync <= pclk_meta;
      pclk_prev <= pclk_sync;
    end
  end

  assign fe        = dclk_prev & ~dclk_sync;
  assign pclk_rise = pclk_sync & ~pclk_prev;

  // FSM state, shift register and timeout counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_count    <= 3'd0;
      shift        <= 8'h00;
      parity_bit   <= 1'b0;
      tmo_count    <= 16'd0;
      pend_good    <= 1'b0;
      pend_parity  <= 1'b0;
      pend_framing <= 1'b0;
      pend_data    <= 8'h00;
    end else begin
      state        <= state_next;
      bit_count    <= bit_count_next;
      shift        <= shift_next;
      parity_bit   <= parity_bit_next;
      tmo_count    <= tmo_count_next;
      pend_good    <= pend_good_next;
      pend_parity  <= pend_parity_next;
      pend_framing <= pend_framing_next;
      pend_data    <= pend_data_next;
    end
  end

  // Next-state logic. A host transmission overrides everything else. A
  // device_clock falling edge comes next, so it beats a timeout that expires
  // in the same cycle. A timeout drops the partial byte.
  always_comb begin
    state_next        = state;
    bit_count_next    = bit_count;
    shift_next        = shift;
    parity_bit_next   = parity_bit;
    tmo_count_next    = tmo_count;
    pend_good_next    = 1'b0;
    pend_parity_next  = 1'b0;
    pend_framing_next = 1'b0;
    pend_data_next    = pend_data;
    tmo_hit           = 1'b0;

    if (sending_data_flag) begin
      state_next     = IDLE;
      bit_count_next = 3'd0;
      tmo_count_next = 16'd0;
    end else if (fe) begin
      tmo_count_next = 16'd0;
      case (state)
        IDLE: begin
          if (!ddat_sync) begin
            state_next     = DATA;
            bit_count_next = 3'd0;
          end
        end
        DATA: begin
          shift_next     = {ddat_sync, shift[7:1]};
          bit_count_next = bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_bit_next = ddat_sync;
          state_next      = STOP;
        end
        STOP: begin
          state_next     = IDLE;
          bit_count_next = 3'd0;
          pend_data_next = shift;
          // A bad stop bit hides any parity fault in the same frame.
          if (!ddat_sync) begin
            pend_framing_next = 1'b1;
          end else if (!(^{shift, parity_bit})) begin
            pend_parity_next = 1'b1;
          end else begin
            pend_good_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state == IDLE) begin
      tmo_count_next = 16'd0;
    end else if (tmo_count >= device_in_timeout) begin
      state_next     = IDLE;
      bit_count_next = 3'd0;
      shift_next     = 8'h00;
      tmo_count_next = 16'd0;
      tmo_hit        = 1'b1;
    end else if (pclk_rise && (tmo_count != 16'hFFFF)) begin
      tmo_count_next = tmo_count + 16'd1;
    end
  end

  // Output stage: load the result of a finished frame, run the valid/ack
  // handshake and produce the one-cycle status pulses. While the host is
  // transmitting, the outputs hold their values and no pulse is raised.
  // A load in the same cycle as an ack replaces the data that was just read,
  // so it is not an overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      received_data <= 8'h00;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      timeout_error <= tmo_hit;
      if (!sending_data_flag) begin
        parity_error  <= pend_parity;
        framing_error <= pend_framing;
        if (pend_good) begin
          received_data <= pend_data;
          data_valid    <= 1'b1;
          overrun       <= data_valid & ~data_ack;
        end else if (data_valid && data_ack) begin
          data_valid <= 1'b0;
        end
      end
    end
  end

endmodule
